gpu_program_loader: RTL

- Host-side controller that drives the shader core's external load/run interface, the initiating end of the core's `ext_write_*` / `run` / `halted` protocol.
- Sequence per job: reset the core, stream instruction words then data words from a valid/ready host stream into the core RAMs, raise run, wait for halted or timeout, then report the cycle count.

---
 rtl/gpu_program_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/gpu_program_loader.sv
// Host-side job controller for the shader core: resets the core, streams instruction
// and data words into its RAMs, runs it until halt or timeout, and reports run cycles.
module gpu_program_loader #(
    parameter int unsigned CORE_RESET_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 1000000,
    parameter int unsigned MAX_WORDS         = 16384
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [14:0] inst_words,
    input  logic [14:0] data_words,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic        error,
    output logic [31:0] cycle_count,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_data,
    output logic        core_reset_n,
    output logic        core_run,
    input  logic        core_halted,
    output logic [15:0] ext_write_address,
    output logic [31:0] ext_write_data,
    output logic        ext_enable_write_inst,
    output logic        ext_enable_write_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORE_RESET,
        S_LOAD_INST,
        S_LOAD_DATA,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [14:0] MAX_W = 15'(MAX_WORDS);

    state_t      state_q;
    logic [14:0] inst_cnt_q;
    logic [14:0] data_cnt_q;
    logic [14:0] idx_q;
    logic [31:0] wait_q;
    logic        busy_q;
    logic        done_q;
    logic        timed_out_q;
    logic        error_q;
    logic [31:0] cycle_count_q;
    logic        core_reset_n_q;
    logic        core_run_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic        en_inst_q;
    logic        en_data_q;

    logic [14:0] idx_d;
    logic        beat;
    logic        last_beat;
    logic        count_bad;

    // Ready depends on state alone so the host never sees a combinational path from its own valid.
    assign host_ready = (state_q == S_LOAD_INST) || (state_q == S_LOAD_DATA);
    assign beat       = host_valid && host_ready;
    assign idx_d      = idx_q + 15'd1;
    assign last_beat  = (idx_d == ((state_q == S_LOAD_INST) ? inst_cnt_q : data_cnt_q));
    assign count_bad  = (inst_words > MAX_W) || (data_words > MAX_W);

    // NOTE: every register in this block uses non-blocking assignment; the later
    // assignment in the same cycle wins, which the IDLE branch relies on.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            inst_cnt_q     <= '0;
            data_cnt_q     <= '0;
            idx_q          <= '0;
            wait_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timed_out_q    <= 1'b0;
            error_q        <= 1'b0;
            cycle_count_q  <= '0;
            core_reset_n_q <= 1'b0;
            core_run_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            en_inst_q      <= 1'b0;
            en_data_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            en_inst_q <= 1'b0;
            en_data_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    core_reset_n_q <= 1'b1;
                    core_run_q     <= 1'b0;
                    if (start) begin
                        if (count_bad) begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            inst_cnt_q     <= inst_words;
                            data_cnt_q     <= data_words;
                            error_q        <= 1'b0;
                            timed_out_q    <= 1'b0;
                            cycle_count_q  <= '0;
                            busy_q         <= 1'b1;
                            core_reset_n_q <= 1'b0;
                            wait_q         <= '0;
                            state_q        <= S_CORE_RESET;
                        end
                    end
                end
                S_CORE_RESET: begin
                    if (wait_q == CORE_RESET_CYCLES - 1) begin
                        core_reset_n_q <= 1'b1;
                        idx_q          <= '0;
                        wait_q         <= '0;
                        if (inst_cnt_q != '0)      state_q <= S_LOAD_INST;
                        else if (data_cnt_q != '0) state_q <= S_LOAD_DATA;
                        else                       state_q <= S_SETTLE;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_LOAD_INST, S_LOAD_DATA: begin
                    if (beat) begin
                        wdata_q <= host_data;
                        addr_q  <= {idx_q[13:0], 2'b00};
                        if (state_q == S_LOAD_INST) en_inst_q <= 1'b1;
                        else                        en_data_q <= 1'b1;
                        idx_q <= idx_d;
                        if (last_beat) begin
                            idx_q  <= '0;
                            wait_q <= '0;
                            if (state_q == S_LOAD_INST && data_cnt_q != '0) state_q <= S_LOAD_DATA;
                            else                                           state_q <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    // The first SETTLE cycle may still carry the final strobe, hence one extra cycle.
                    if (wait_q == SETTLE_CYCLES) begin
                        core_run_q <= 1'b1;
                        state_q    <= S_RUN;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_RUN: begin
                    cycle_count_q <= cycle_count_q + 32'd1;
                    if (core_halted) begin
                        core_run_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else if (cycle_count_q == TIMEOUT_CYCLES - 1) begin
                        timed_out_q <= 1'b1;
                        core_run_q  <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign timed_out             = timed_out_q;
    assign error                 = error_q;
    assign cycle_count           = cycle_count_q;
    assign core_reset_n          = core_reset_n_q;
    assign core_run              = core_run_q;
    assign ext_write_address     = addr_q;
    assign ext_write_data        = wdata_q;
    assign ext_enable_write_inst = en_inst_q;
    assign ext_enable_write_data = en_data_q;

endmodule
